wb_regfile: RTL and testbench



---
 rtl/wb_regfile_pkg.sv | 22 ++
 rtl/wb_mux.sv | 21 ++
 rtl/wb_regfile.sv | 87 ++++++++
 tb/tb_wb_regfile.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// Module   : wb_regfile_pkg
// Purpose  : Shared pipeline types and constants for the write-back stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  // Shared by the ID/EX, EX/MEM, MEM/WB registers and the forwarding unit
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_word_t;

endpackage

`default_nettype wire

// File: rtl/wb_mux.sv
// ============================================================================
// Module   : wb_mux
// Purpose  : MemtoReg select between load data and ALU result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mux #(
  parameter int DATA_W = 32
) (
  input  logic              i_mem_to_reg,
  input  logic [DATA_W-1:0] i_mdr,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic [DATA_W-1:0] o_wb_data
);

  assign o_wb_data = i_mem_to_reg ? i_mdr : i_alu_result;

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// Module   : wb_regfile
// Purpose  : MEM/WB write-back select, 32x32 register file with two read
//            ports, forwarding export and committed-write counter.
//            Optional macro WB_BYPASS_EN: write-through on read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] mdr_i,
  input  logic [DATA_W-1:0] ALU_result_i,
  input  logic              MemtoReg_i,
  input  logic              RegWr_i,
  input  logic [ADDR_W-1:0] EX_MUX_i,
  input  logic [ADDR_W-1:0] RS_addr_i,
  input  logic [ADDR_W-1:0] RT_addr_i,
  output logic [DATA_W-1:0] RS_data_o,
  output logic [DATA_W-1:0] RT_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic              wb_en_o,
  output logic [31:0]       wb_cnt_o
);

  import wb_regfile_pkg::*;

  localparam logic [ADDR_W-1:0] c_zero = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [31:0]       r_wb_cnt;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_en;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;

  wb_mux #(
    .DATA_W(DATA_W)
  ) u_wb_mux (
    .i_mem_to_reg(MemtoReg_i),
    .i_mdr       (mdr_i),
    .i_alu_result(ALU_result_i),
    .o_wb_data   (w_wb_data)
  );

  // Writes to r0 are squashed here so they neither commit nor count
  assign w_wb_en = RegWr_i && (EX_MUX_i != c_zero);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wb_cnt <= '0;
    end else if (w_wb_en) begin
      r_regs[EX_MUX_i] <= w_wb_data;
      r_wb_cnt         <= r_wb_cnt + 32'd1;
    end
  end

  always_comb begin
    w_rs_data = (RS_addr_i == c_zero) ? '0 : r_regs[RS_addr_i];
    w_rt_data = (RT_addr_i == c_zero) ? '0 : r_regs[RT_addr_i];
`ifdef WB_BYPASS_EN
    // Pending write is visible in the same cycle; w_wb_en already excludes r0
    if (w_wb_en && (RS_addr_i == EX_MUX_i)) w_rs_data = w_wb_data;
    if (w_wb_en && (RT_addr_i == EX_MUX_i)) w_rt_data = w_wb_data;
`else
`endif
  end

  assign RS_data_o = w_rs_data;
  assign RT_data_o = w_rt_data;
  assign wb_data_o = w_wb_data;
  assign wb_addr_o = EX_MUX_i;
  assign wb_en_o   = w_wb_en;
  assign wb_cnt_o  = r_wb_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Directed self-checking bench for wb_regfile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] mdr;
  logic [31:0] alu;
  logic        m2r;
  logic        we;
  logic [4:0]  wa;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_en;
  logic [31:0] wb_cnt;

  int total = 0;
  int bad   = 0;

  wb_regfile dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mdr_i       (mdr),
    .ALU_result_i(alu),
    .MemtoReg_i  (m2r),
    .RegWr_i     (we),
    .EX_MUX_i    (wa),
    .RS_addr_i   (ra),
    .RT_addr_i   (rb),
    .RS_data_o   (rs_data),
    .RT_data_o   (rt_data),
    .wb_data_o   (wb_data),
    .wb_addr_o   (wb_addr),
    .wb_en_o     (wb_en),
    .wb_cnt_o    (wb_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // MEM/WB outputs change on the falling edge
  task automatic drive(input logic i_we, input logic i_m2r, input logic [4:0] i_wa,
                       input logic [31:0] i_alu, input logic [31:0] i_mdr,
                       input logic [4:0] i_ra, input logic [4:0] i_rb);
    @(negedge clk);
    we = i_we; m2r = i_m2r; wa = i_wa; alu = i_alu; mdr = i_mdr; ra = i_ra; rb = i_rb;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_pre9;

  initial begin
    rst = 1'b0; we = 1'b0; m2r = 1'b0; wa = '0; alu = '0; mdr = '0; ra = '0; rb = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset_rs", rs_data, 32'h0);
    chk("reset_cnt", wb_cnt, 32'h0);
    chk("reset_en", 32'(wb_en), 32'h0);
    @(negedge clk) rst = 1'b0;

    // reg5 = 0x1234, reg3 = 0x5, then mid-cycle reset
    drive(1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'h0, 5'd5, 5'd3);
    edge_step();
    chk("w5_rs", rs_data, 32'h0000_1234);
    chk("w5_cnt", wb_cnt, 32'd1);
    drive(1'b1, 1'b0, 5'd3, 32'h0000_0005, 32'h0, 5'd5, 5'd3);
    edge_step();
    chk("w3_rt", rt_data, 32'h5);
    chk("w3_cnt", wb_cnt, 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("async_rs5", rs_data, 32'h0);
    chk("async_rt3", rt_data, 32'h0);
    chk("async_cnt", wb_cnt, 32'h0);
    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;

    // First edge after reset release commits
    drive(1'b1, 1'b0, 5'd3, 32'h0000_0005, 32'h0, 5'd3, 5'd3);
    edge_step();
    chk("rel_rs3", rs_data, 32'h5);
    chk("rel_cnt", wb_cnt, 32'd1);

    // ALU write-back
    drive(1'b1, 1'b0, 5'd7, 32'hDEAD_BEEF, 32'h1111_1111, 5'd7, 5'd3);
    chk("alu_wbdata", wb_data, 32'hDEAD_BEEF);
    chk("alu_wbaddr", 32'(wb_addr), 32'd7);
    chk("alu_wben", 32'(wb_en), 32'd1);
    edge_step();
    chk("alu_rs7", rs_data, 32'hDEAD_BEEF);
    chk("alu_cnt", wb_cnt, 32'd2);

    // Load write-back
    drive(1'b1, 1'b1, 5'd31, 32'h1111_1111, 32'hCAFE_F00D, 5'd7, 5'd31);
    chk("ld_wbdata", wb_data, 32'hCAFE_F00D);
    edge_step();
    chk("ld_rt31", rt_data, 32'hCAFE_F00D);
    chk("ld_rs7", rs_data, 32'hDEAD_BEEF);
    chk("ld_cnt", wb_cnt, 32'd3);

    // r0 protection
    drive(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
    chk("r0_wben", 32'(wb_en), 32'd0);
    chk("r0_pre_rs", rs_data, 32'h0);
    edge_step();
    chk("r0_rs", rs_data, 32'h0);
    chk("r0_rt", rt_data, 32'h0);
    chk("r0_cnt", wb_cnt, 32'd3);

    // Disabled write
    drive(1'b0, 1'b0, 5'd3, 32'h0000_AAAA, 32'h0000_AAAA, 5'd3, 5'd31);
    chk("dis_wben", 32'(wb_en), 32'd0);
    edge_step();
    chk("dis_rs3", rs_data, 32'h5);
    chk("dis_rt31", rt_data, 32'hCAFE_F00D);
    chk("dis_cnt", wb_cnt, 32'd3);

    // Same-cycle read/write on reg9
    drive(1'b1, 1'b0, 5'd9, 32'h1, 32'h0, 5'd9, 5'd9);
    edge_step();
    chk("r9_init", rs_data, 32'h1);
    drive(1'b1, 1'b0, 5'd9, 32'h2, 32'h0, 5'd9, 5'd9);
`ifdef WB_BYPASS_EN
    exp_pre9 = 32'h2;
`else
    exp_pre9 = 32'h1;
`endif
    chk("r9_pre_rs", rs_data, exp_pre9);
    chk("r9_pre_rt", rt_data, exp_pre9);
    edge_step();
    chk("r9_post_rs", rs_data, 32'h2);
    chk("r9_post_rt", rt_data, 32'h2);
    chk("r9_cnt", wb_cnt, 32'd5);

    // Reset at a clock edge with a write pending: no write, no count
    @(negedge clk);
    we = 1'b1; m2r = 1'b0; wa = 5'd10; alu = 32'h77; ra = 5'd10; rb = 5'd9;
    rst = 1'b1;
    edge_step();
    chk("rstedge_rs10", rs_data, 32'h0);
    chk("rstedge_cnt", wb_cnt, 32'h0);
    @(negedge clk) rst = 1'b0;
    we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
